// File: rtl/wb_defer_pipe_pkg.sv
// Shared types and limits for the writeback-deferral pipeline.
// Optional statistics counters are enabled with WB_STATS_EN.
package wb_defer_pipe_pkg;

  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_MIN     = 1;
  localparam int SEL_W_MAX   = 8;
  localparam int ADDR_W_MAX  = 32;

  // Fields are sized for the widest legal build and narrowed by the users.
  typedef struct packed {
    logic                  valid;
    logic                  we0;
    logic                  we1;
    logic [SEL_W_MAX-1:0]  sel0;
    logic [SEL_W_MAX-1:0]  sel1;
    logic [ADDR_W_MAX-1:0] addr;
    logic                  ret;
  } pipe_entry_t;

endpackage

// File: rtl/wb_defer_pipe_if.sv
// Decode-side and writeback-side signals of the deferral pipeline.
// The statistics ports (WB_STATS_EN) sit on the top module itself.
interface wb_defer_pipe_if #(
  parameter int SEL_W  = 4,
  parameter int ADDR_W = 14
);

  logic              in_valid;
  logic              in_mem_read;
  logic              in_ret;
  logic              in_we0;
  logic              in_we1;
  logic [SEL_W-1:0]  in_sel0;
  logic [SEL_W-1:0]  in_sel1;
  logic [SEL_W-1:0]  in_src_a;
  logic [SEL_W-1:0]  in_src_b;
  logic [ADDR_W-1:0] in_addr;
  logic              flush;
  logic              stall;
  logic              out_we0;
  logic              out_we1;
  logic [SEL_W-1:0]  out_sel0;
  logic [SEL_W-1:0]  out_sel1;
  logic [ADDR_W-1:0] out_addr;
  logic              out_from_mem;
  logic              out_ret_pend;

  modport master (
    output in_valid, in_mem_read, in_ret,
    output in_we0, in_we1, in_sel0, in_sel1,
    output in_src_a, in_src_b, in_addr, flush,
    input  stall, out_we0, out_we1,
    input  out_sel0, out_sel1, out_addr,
    input  out_from_mem, out_ret_pend
  );

  modport slave (
    input  in_valid, in_mem_read, in_ret,
    input  in_we0, in_we1, in_sel0, in_sel1,
    input  in_src_a, in_src_b, in_addr, flush,
    output stall, out_we0, out_we1,
    output out_sel0, out_sel1, out_addr,
    output out_from_mem, out_ret_pend
  );

endinterface

// File: rtl/wb_hazard_cmp.sv
// Load-use compare of one in-flight pipe entry against both
// source selectors of the live instruction.
module wb_hazard_cmp #(
  parameter int SEL_W = 4
) (
  input  logic             valid,
  input  logic             we0,
  input  logic             we1,
  input  logic [SEL_W-1:0] sel0,
  input  logic [SEL_W-1:0] sel1,
  input  logic [SEL_W-1:0] src_a,
  input  logic [SEL_W-1:0] src_b,
  output logic             hit
);

  logic hit0;
  logic hit1;

  assign hit0 = we0 & ((sel0 == src_a) | (sel0 == src_b));
  assign hit1 = we1 & ((sel1 == src_a) | (sel1 == src_b));
  assign hit  = valid & (hit0 | hit1);

endmodule

// File: rtl/wb_defer_pipe.sv
// Defers load/return writebacks by MEM_LAT cycles and stalls decode.
// Define WB_STATS_EN to add saturating stall_cnt/load_cnt ports.
module wb_defer_pipe
  import wb_defer_pipe_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 14,
  parameter int SEL_W   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  wb_defer_pipe_if.slave bus
`ifdef WB_STATS_EN
  ,
  output logic [15:0]    stall_cnt,
  output logic [15:0]    load_cnt
`endif
);

  if (MEM_LAT < LAT_MIN || MEM_LAT > MEM_LAT_MAX)
    $error("wb_defer_pipe: MEM_LAT out of range");
  if (SEL_W > SEL_W_MAX || ADDR_W > ADDR_W_MAX || DATA_W < 1)
    $error("wb_defer_pipe: width parameter out of range");

  pipe_entry_t        p [MEM_LAT];
  pipe_entry_t        slot;
  pipe_entry_t        push;
  logic [MEM_LAT-1:0] hit;
  logic               is_load;
  logic               effect;
  logic               rule1;
  logic               rule2;
  logic               stall_i;
  logic               accepted;

  assign slot    = p[MEM_LAT-1];
  assign is_load = bus.in_mem_read | bus.in_ret;
  assign effect  = bus.in_we0 | bus.in_we1 | is_load;

  for (genvar k = 0; k < MEM_LAT; k++) begin : g_cmp
    wb_hazard_cmp #(.SEL_W(SEL_W)) u_cmp (
      .valid (p[k].valid),
      .we0   (p[k].we0),
      .we1   (p[k].we1),
      .sel0  (SEL_W'(p[k].sel0)),
      .sel1  (SEL_W'(p[k].sel1)),
      .src_a (bus.in_src_a),
      .src_b (bus.in_src_b),
      .hit   (hit[k])
    );
  end

  assign rule1    = slot.valid & effect;
  assign rule2    = |hit;
  assign stall_i  = ~reset & bus.in_valid & ~bus.flush
                  & (rule1 | rule2);
  assign accepted = ~reset & bus.in_valid & ~stall_i
                  & ~bus.flush;

  always_comb begin
    push       = '0;
    push.valid = accepted & is_load;
    push.we0   = bus.in_we0;
    push.we1   = bus.in_we1;
    push.sel0  = SEL_W_MAX'(bus.in_sel0);
    push.sel1  = SEL_W_MAX'(bus.in_sel1);
    push.addr  = ADDR_W_MAX'(bus.in_addr);
    push.ret   = bus.in_ret;
  end

  // Shifts every cycle, stalled or not, so in-flight loads always drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MEM_LAT; k++) p[k] <= '0;
    end else begin
      p[0] <= push;
      for (int k = 1; k < MEM_LAT; k++) p[k] <= p[k-1];
    end
  end

  always_comb begin
    bus.stall        = stall_i;
    bus.out_we0      = 1'b0;
    bus.out_we1      = 1'b0;
    bus.out_sel0     = bus.in_sel0;
    bus.out_sel1     = bus.in_sel1;
    bus.out_addr     = bus.in_addr;
    bus.out_from_mem = 1'b0;
    bus.out_ret_pend = 1'b0;
    priority case (1'b1)
      reset: ;
      slot.valid: begin
        bus.out_we0      = slot.we0;
        bus.out_we1      = slot.we1;
        bus.out_sel0     = SEL_W'(slot.sel0);
        bus.out_sel1     = SEL_W'(slot.sel1);
        bus.out_addr     = ADDR_W'(slot.addr);
        bus.out_from_mem = 1'b1;
        bus.out_ret_pend = slot.ret;
      end
      accepted & ~is_load: begin
        bus.out_we0 = bus.in_we0;
        bus.out_we1 = bus.in_we1;
      end
      default: ;
    endcase
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      load_cnt  <= '0;
    end else begin
      if (stall_i && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (accepted && is_load && load_cnt != 16'hFFFF)
        load_cnt <= load_cnt + 16'd1;
    end
  end
`endif

endmodule
